// File: rtl/fir_bram_sched.sv
// fir_bram_sched: sequencer for an 11-tap FIR on a tap RAM and a circular data RAM.
// Takes one sample per AXI-Stream handshake, issues NUM_TAPS paired reads,
// accumulates the wrapped products and presents the result on the master
// stream. The run is bracketed by ap_start / ap_done / ap_idle.
module fir_bram_sched #(
  parameter int NUM_TAPS   = 11,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  ap_start,
  input  logic [31:0]           data_length,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic                  ss_tvalid,
  input  logic [DATA_WIDTH-1:0] ss_tdata,
  output logic                  ss_tready,
  output logic                  sm_tvalid,
  output logic [DATA_WIDTH-1:0] sm_tdata,
  output logic                  sm_tlast,
  input  logic                  sm_tready,
  output logic                  tap_re,
  output logic [ADDR_WIDTH-1:0] tap_raddr,
  input  logic [DATA_WIDTH-1:0] tap_rdo,
  output logic                  data_we,
  output logic                  data_re,
  output logic [ADDR_WIDTH-1:0] data_waddr,
  output logic [ADDR_WIDTH-1:0] data_raddr,
  output logic [DATA_WIDTH-1:0] data_wdi,
  input  logic [DATA_WIDTH-1:0] data_rdo
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_IN = 3'd2,
    S_ISSUE   = 3'd3,
    S_DRAIN   = 3'd4,
    S_OUTPUT  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                  state_q;
  logic [31:0]             len_q;
  logic [31:0]             count_q;
  logic [ADDR_WIDTH-1:0]   head_q;
  logic [ADDR_WIDTH-1:0]   k_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    clr_we_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic                    ap_idle_q;
  logic                    ap_done_q;
  logic                    ss_tready_q;
  logic                    sm_tvalid_q;
  logic [DATA_WIDTH-1:0]   sm_tdata_q;
  logic                    sm_tlast_q;
  logic                    tap_re_q;
  logic [ADDR_WIDTH-1:0]   tap_raddr_q;
  logic                    data_re_q;
  logic [ADDR_WIDTH-1:0]   data_raddr_q;

  logic                    ss_hs_s;
  logic                    sm_hs_s;
  logic                    acc_en_s;
  logic [DATA_WIDTH-1:0]   prod_s;
  logic [DATA_WIDTH-1:0]   acc_d;
  logic [ADDR_WIDTH-1:0]   head_d;
  logic [ADDR_WIDTH-1:0]   raddr_d;
  logic                    last_d;

  // Handshakes, wrapped MAC, circular index arithmetic and last-output flag.
  always_comb begin
    ss_hs_s  = ss_tvalid & ss_tready_q;
    sm_hs_s  = sm_tvalid_q & sm_tready;
    // RAM data returns one cycle after a read, so k=0 has nothing to add yet.
    acc_en_s = ((state_q == S_ISSUE) && (k_q != ZERO_IDX)) || (state_q == S_DRAIN);
    prod_s   = tap_rdo * data_rdo;
    acc_d    = acc_q + prod_s;
    if (head_q == LAST_IDX) begin
      head_d = ZERO_IDX;
    end else begin
      head_d = head_q + ONE_IDX;
    end
    if (data_raddr_q == ZERO_IDX) begin
      raddr_d = LAST_IDX;
    end else begin
      raddr_d = data_raddr_q - ONE_IDX;
    end
    last_d = ((count_q + 32'd1) == len_q);
  end

  // Main sequencer: state, counters, accumulator and all registered outputs.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= 32'd0;
      count_q      <= 32'd0;
      head_q       <= ZERO_IDX;
      k_q          <= ZERO_IDX;
      clr_addr_q   <= ZERO_IDX;
      clr_we_q     <= 1'b0;
      acc_q        <= {DATA_WIDTH{1'b0}};
      ap_idle_q    <= 1'b1;
      ap_done_q    <= 1'b0;
      ss_tready_q  <= 1'b0;
      sm_tvalid_q  <= 1'b0;
      sm_tdata_q   <= {DATA_WIDTH{1'b0}};
      sm_tlast_q   <= 1'b0;
      tap_re_q     <= 1'b0;
      tap_raddr_q  <= ZERO_IDX;
      data_re_q    <= 1'b0;
      data_raddr_q <= ZERO_IDX;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            len_q      <= data_length;
            count_q    <= 32'd0;
            head_q     <= ZERO_IDX;
            clr_addr_q <= ZERO_IDX;
            clr_we_q   <= 1'b1;
            ap_idle_q  <= 1'b0;
            state_q    <= S_CLEAR;
          end else begin
            ap_idle_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clr_addr_q == LAST_IDX) begin
            clr_we_q   <= 1'b0;
            clr_addr_q <= ZERO_IDX;
            if (len_q == 32'd0) begin
              ap_done_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              ss_tready_q <= 1'b1;
              state_q     <= S_WAIT_IN;
            end
          end else begin
            clr_addr_q <= clr_addr_q + ONE_IDX;
          end
        end
        S_WAIT_IN: begin
          // The sample itself is written combinationally in the handshake cycle.
          if (ss_hs_s) begin
            ss_tready_q  <= 1'b0;
            acc_q        <= {DATA_WIDTH{1'b0}};
            k_q          <= ZERO_IDX;
            tap_re_q     <= 1'b1;
            tap_raddr_q  <= ZERO_IDX;
            data_re_q    <= 1'b1;
            data_raddr_q <= head_q;
            state_q      <= S_ISSUE;
          end else begin
            ss_tready_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (acc_en_s) begin
            acc_q <= acc_d;
          end else begin
            acc_q <= acc_q;
          end
          if (k_q == LAST_IDX) begin
            tap_re_q  <= 1'b0;
            data_re_q <= 1'b0;
            state_q   <= S_DRAIN;
          end else begin
            k_q          <= k_q + ONE_IDX;
            tap_raddr_q  <= k_q + ONE_IDX;
            data_raddr_q <= raddr_d;
          end
        end
        S_DRAIN: begin
          acc_q       <= acc_d;
          sm_tdata_q  <= acc_d;
          sm_tlast_q  <= last_d;
          sm_tvalid_q <= 1'b1;
          state_q     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (sm_hs_s) begin
            sm_tvalid_q <= 1'b0;
            sm_tlast_q  <= 1'b0;
            count_q     <= count_q + 32'd1;
            head_q      <= head_d;
            if (sm_tlast_q) begin
              ap_done_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              ss_tready_q <= 1'b1;
              state_q     <= S_WAIT_IN;
            end
          end else begin
            sm_tvalid_q <= 1'b1;
          end
        end
        S_DONE: begin
          ap_done_q <= 1'b0;
          ap_idle_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          ap_idle_q    <= 1'b1;
          ap_done_q    <= 1'b0;
          ss_tready_q  <= 1'b0;
          sm_tvalid_q  <= 1'b0;
          tap_re_q     <= 1'b0;
          data_re_q    <= 1'b0;
          clr_we_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ap_done    = ap_done_q;
  assign ap_idle    = ap_idle_q;
  assign ss_tready  = ss_tready_q;
  assign sm_tvalid  = sm_tvalid_q;
  assign sm_tdata   = sm_tdata_q;
  assign sm_tlast   = sm_tlast_q;
  assign tap_re     = tap_re_q;
  assign tap_raddr  = tap_raddr_q;
  assign data_re    = data_re_q;
  assign data_raddr = data_raddr_q;
  assign data_we    = clr_we_q | ss_hs_s;
  assign data_waddr = ss_hs_s ? head_q : clr_addr_q;
  assign data_wdi   = ss_hs_s ? ss_tdata : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_fir_bram_sched.sv
// Bench for fir_bram_sched: RAM models, vector table, expected-value queue.
module tb_fir_bram_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_done, ap_idle;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready;
  logic        tap_re;
  logic [11:0] tap_raddr;
  logic [31:0] tap_rdo;
  logic        data_we, data_re;
  logic [11:0] data_waddr, data_raddr;
  logic [31:0] data_wdi;
  logic [31:0] data_rdo;

  logic [31:0] tap_mem [0:10];
  logic [31:0] data_mem [0:10];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          len;
    int          bp_idx;
    logic [31:0] tapv [11];
    logic [31:0] din  [12];
    logic [31:0] dexp [12];
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  vec_t vecs [6];
  exp_t exp_q [$];

  fir_bram_sched dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .ap_start(ap_start), .data_length(data_length),
    .ap_done(ap_done), .ap_idle(ap_idle),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .tap_re(tap_re), .tap_raddr(tap_raddr), .tap_rdo(tap_rdo),
    .data_we(data_we), .data_re(data_re), .data_waddr(data_waddr),
    .data_raddr(data_raddr), .data_wdi(data_wdi), .data_rdo(data_rdo)
  );

  always #5 clk = ~clk;

  // Block RAM models with one-cycle read latency.
  always @(posedge clk) begin
    if (tap_re && tap_raddr < 12'd11) tap_rdo <= tap_mem[tap_raddr[3:0]];
    if (data_re && data_raddr < 12'd11) data_rdo <= data_mem[data_raddr[3:0]];
    if (data_we && data_waddr < 12'd11) data_mem[data_waddr[3:0]] <= data_wdi;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Advance one cycle; check RAM port sanity mid-cycle.
  task automatic step();
    @(negedge clk);
    if (data_re) chk("raddr_range", {31'd0, data_raddr < 12'd11}, 32'd1);
    if (data_re && data_we) chk("rw_collision", {31'd0, data_raddr != data_waddr}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_vec(input int v);
    int n;
    int m;
    exp_t e;
    logic [31:0] held;
    for (int k = 0; k < 11; k++) tap_mem[k] = vecs[v].tapv[k];
    chk("idle_before", {31'd0, ap_idle}, 32'd1);
    data_length = vecs[v].len;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    chk("idle_fall", {31'd0, ap_idle}, 32'd0);
    n = 1;
    for (int j = 0; j < vecs[v].len; j++) begin
      while (!ss_tready && n < 64) begin step(); n++; end
      if (j == 0) chk("start_to_ready", n, 32'd12);
      if (!ss_tready) begin chk("ready_timeout", 32'd0, 32'd1); return; end
      ss_tvalid = 1'b1;
      ss_tdata  = vecs[v].din[j];
      exp_q.push_back('{data: vecs[v].dexp[j], last: (j == vecs[v].len - 1)});
      step();
      ss_tvalid = 1'b0;
      m = 1;
      while (!sm_tvalid && m < 64) begin step(); m++; end
      chk("hs_to_valid", m, 32'd13);
      if (!sm_tvalid) return;
      if (j == vecs[v].bp_idx) begin
        held = sm_tdata;
        for (int b = 0; b < 5; b++) begin
          chk("bp_valid", {31'd0, sm_tvalid}, 32'd1);
          chk("bp_data", sm_tdata, held);
          chk("bp_ready_low", {31'd0, ss_tready}, 32'd0);
          step();
        end
      end
      sm_tready = 1'b1;
      if (exp_q.size() == 0) begin
        chk("queue_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_out%0d", v, j), sm_tdata, e.data);
        chk($sformatf("v%0d_last%0d", v, j), {31'd0, sm_tlast}, {31'd0, e.last});
      end
      step();
      sm_tready = 1'b0;
      n = 0;
    end
    chk("done_pulse", {31'd0, ap_done}, 32'd1);
    step();
    chk("done_clear", {31'd0, ap_done}, 32'd0);
    chk("idle_after", {31'd0, ap_idle}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    logic any_out;
    // Vector table
    for (int v = 0; v < 6; v++) begin
      vecs[v].len = 0;
      vecs[v].bp_idx = -1;
      for (int k = 0; k < 11; k++) vecs[v].tapv[k] = 32'd0;
      for (int k = 0; k < 12; k++) begin vecs[v].din[k] = 32'd0; vecs[v].dexp[k] = 32'd0; end
    end
    // 0: taps all 1, running sums, backpressure on third output
    vecs[0].len = 5; vecs[0].bp_idx = 2;
    for (int k = 0; k < 11; k++) vecs[0].tapv[k] = 32'd1;
    for (int k = 0; k < 5; k++) vecs[0].din[k] = k + 1;
    vecs[0].dexp[0] = 32'd1; vecs[0].dexp[1] = 32'd3; vecs[0].dexp[2] = 32'd6;
    vecs[0].dexp[3] = 32'd10; vecs[0].dexp[4] = 32'd15;
    // 1: tap[k]=k, impulse walks the taps and then falls out of the window
    vecs[1].len = 12;
    for (int k = 0; k < 11; k++) vecs[1].tapv[k] = k;
    vecs[1].din[0] = 32'd1;
    for (int k = 0; k < 11; k++) vecs[1].dexp[k] = k;
    vecs[1].dexp[11] = 32'd0;
    // 2: taps 1, inputs 7
    vecs[2].len = 4;
    for (int k = 0; k < 11; k++) vecs[2].tapv[k] = 32'd1;
    for (int k = 0; k < 4; k++) vecs[2].din[k] = 32'd7;
    vecs[2].dexp[0] = 32'd7; vecs[2].dexp[1] = 32'd14; vecs[2].dexp[2] = 32'd21; vecs[2].dexp[3] = 32'd28;
    // 3: taps 1, inputs 0 right after vector 2 -> all zero
    vecs[3].len = 4;
    for (int k = 0; k < 11; k++) vecs[3].tapv[k] = 32'd1;
    // 4: product and sum wrap at 32 bits
    vecs[4].len = 3;
    vecs[4].tapv[0] = 32'h8000_0000; vecs[4].tapv[1] = 32'h8000_0000; vecs[4].tapv[2] = 32'd1;
    vecs[4].din[0] = 32'd2; vecs[4].din[1] = 32'd3; vecs[4].din[2] = 32'hFFFF_FFFF;
    vecs[4].dexp[0] = 32'h0000_0000; vecs[4].dexp[1] = 32'h8000_0000; vecs[4].dexp[2] = 32'h0000_0002;
    // 5: after mid-run reset, taps 1 and input 2
    vecs[5].len = 1;
    for (int k = 0; k < 11; k++) vecs[5].tapv[k] = 32'd1;
    vecs[5].din[0] = 32'd2; vecs[5].dexp[0] = 32'd2;

    rst_n = 1'b0; ap_start = 1'b0; data_length = 32'd0;
    ss_tvalid = 1'b0; ss_tdata = 32'd0; sm_tready = 1'b0;
    for (int k = 0; k < 11; k++) tap_mem[k] = 32'd0;
    step(); step();
    any_out = |{ap_done, ss_tready, sm_tvalid, sm_tdata, sm_tlast, tap_re, tap_raddr,
                data_we, data_re, data_waddr, data_raddr, data_wdi};
    chk("reset_outs_zero", {31'd0, any_out}, 32'd0);
    chk("reset_idle", {31'd0, ap_idle}, 32'd1);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) do_vec(v);

    // data_length = 0: CLEAR only, then DONE, no output
    data_length = 32'd0;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    n = 1; seen = 1'b0;
    while (!ap_done && n < 40) begin
      if (sm_tvalid) seen = 1'b1;
      step(); n++;
    end
    chk("len0_done_cycle", n, 32'd12);
    chk("len0_no_valid", {31'd0, seen}, 32'd0);
    step();
    chk("len0_idle", {31'd0, ap_idle}, 32'd1);

    // Reset asserted while ISSUE is reading
    for (int k = 0; k < 11; k++) tap_mem[k] = 32'd1;
    data_length = 32'd3;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    n = 0;
    while (!ss_tready && n < 40) begin step(); n++; end
    chk("rst_seq_ready", {31'd0, ss_tready}, 32'd1);
    ss_tvalid = 1'b1; ss_tdata = 32'd5;
    step();
    ss_tvalid = 1'b0;
    step(); step(); step();
    chk("rst_seq_in_issue", {31'd0, tap_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    any_out = |{ap_done, ss_tready, sm_tvalid, sm_tdata, sm_tlast, tap_re, tap_raddr,
                data_we, data_re, data_waddr, data_raddr, data_wdi};
    chk("midrun_rst_outs_zero", {31'd0, any_out}, 32'd0);
    chk("midrun_rst_idle", {31'd0, ap_idle}, 32'd1);
    step();
    rst_n = 1'b1;
    step();
    exp_q.delete();
    do_vec(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
